serial_link: RTL and testbench

SERIAL_LINK -- requirements
Module: serial_link

---
 rtl/serial_link.sv | 187 ++++++++++++++++++
 tb/tb_serial_link.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link.sv
// Credit-flow-controlled serializer/deserializer: parallel words go out MSB-first as
// SERIAL_WIDTH beats, and received beats are reassembled into a small receive FIFO.
// Optional beat parity is enabled by defining SERIAL_LINK_PARITY_EN.
module serial_link #(
    parameter int SERIAL_WIDTH   = 4,
    parameter int PARALLEL_WIDTH = 32,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PARALLEL_WIDTH-1:0] in_data,
    output logic                      tx_svalid,
    output logic [SERIAL_WIDTH-1:0]   tx_sout,
    input  logic                      tx_credit,
    input  logic                      rx_svalid,
    input  logic [SERIAL_WIDTH-1:0]   rx_sin,
    output logic                      rx_credit,
`ifdef SERIAL_LINK_PARITY_EN
    output logic                      tx_spar,
    input  logic                      rx_spar,
    output logic                      rx_perr,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PARALLEL_WIDTH-1:0] out_data,
    output logic                      rx_overflow
);
    localparam int BEATS = (PARALLEL_WIDTH + SERIAL_WIDTH - 1) / SERIAL_WIDTH;
    localparam int TW    = BEATS * SERIAL_WIDTH;
    localparam int PAD   = TW - PARALLEL_WIDTH;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CRW   = $clog2(FIFO_DEPTH + 1);
    localparam int PTW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [CRW-1:0] DEPTH_CNT = CRW'(FIFO_DEPTH);
    localparam logic [PTW-1:0] PTR_LAST  = PTW'(FIFO_DEPTH - 1);

    typedef enum logic {IDLE, TRANSMIT} tx_state_t;

    tx_state_t        tx_state;
    logic [TW-1:0]    tx_shreg;
    logic [BCW-1:0]   tx_beat;
    logic [CRW-1:0]   credits;
    logic [TW-1:0]    tx_load;
    logic             tx_accept;

    // Word is left-justified so the zero padding lands in the last beat's LSBs.
    assign tx_load   = TW'(in_data) << PAD;
    assign in_ready  = (tx_state == IDLE) && (credits != '0);
    assign tx_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state  <= IDLE;
            tx_shreg  <= '0;
            tx_beat   <= '0;
            tx_svalid <= 1'b0;
            tx_sout   <= '0;
`ifdef SERIAL_LINK_PARITY_EN
            tx_spar   <= 1'b0;
`endif
        end else begin
            case (tx_state)
                IDLE: begin
                    if (tx_accept) begin
                        tx_state  <= TRANSMIT;
                        tx_svalid <= 1'b1;
                        tx_sout   <= tx_load[TW-1 -: SERIAL_WIDTH];
                        tx_shreg  <= tx_load << SERIAL_WIDTH;
                        tx_beat   <= '0;
`ifdef SERIAL_LINK_PARITY_EN
                        tx_spar   <= ^tx_load[TW-1 -: SERIAL_WIDTH];
`endif
                    end
                end
                TRANSMIT: begin
                    if (tx_beat == LAST_BEAT) begin
                        tx_state  <= IDLE;
                        tx_svalid <= 1'b0;
                    end else begin
                        tx_svalid <= 1'b1;
                        tx_sout   <= tx_shreg[TW-1 -: SERIAL_WIDTH];
                        tx_shreg  <= tx_shreg << SERIAL_WIDTH;
                        tx_beat   <= tx_beat + 1'b1;
`ifdef SERIAL_LINK_PARITY_EN
                        tx_spar   <= ^tx_shreg[TW-1 -: SERIAL_WIDTH];
`endif
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Credits mirror free receiver FIFO slots; returns beyond FIFO_DEPTH are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits <= DEPTH_CNT;
        end else if (tx_accept && !tx_credit) begin
            credits <= credits - 1'b1;
        end else if (!tx_accept && tx_credit && (credits != DEPTH_CNT)) begin
            credits <= credits + 1'b1;
        end
    end

    logic                      rx_vld_q;
    logic [SERIAL_WIDTH-1:0]   rx_sin_q;
    logic [BCW-1:0]            rx_cnt;
    logic [TW-1:0]             rx_shreg;
    logic [TW-1:0]             rx_next;
    logic [PARALLEL_WIDTH-1:0] rx_word;
    logic                      push_req;
    logic                      push;
    logic                      pop;
    logic                      fifo_full;

    logic [PARALLEL_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTW-1:0]            wr_ptr;
    logic [PTW-1:0]            rd_ptr;
    logic [CRW-1:0]            count;

    assign rx_next   = (rx_shreg << SERIAL_WIDTH) | TW'(rx_sin_q);
    assign rx_word   = rx_next[TW-1 -: PARALLEL_WIDTH];
    assign push_req  = rx_vld_q && (rx_cnt == LAST_BEAT);
    assign fifo_full = (count == DEPTH_CNT);
    assign push      = push_req && !fifo_full;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

`ifdef SERIAL_LINK_PARITY_EN
    logic rx_spar_q;
`endif

    // Beats are registered at the pins before assembly, which sets loopback latency to BEATS+2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_vld_q    <= 1'b0;
            rx_sin_q    <= '0;
            rx_cnt      <= '0;
            rx_shreg    <= '0;
            rx_overflow <= 1'b0;
`ifdef SERIAL_LINK_PARITY_EN
            rx_spar_q   <= 1'b0;
            rx_perr     <= 1'b0;
`endif
        end else begin
            rx_vld_q <= rx_svalid;
            rx_sin_q <= rx_sin;
            if (rx_vld_q) begin
                rx_shreg <= rx_next;
                rx_cnt   <= (rx_cnt == LAST_BEAT) ? '0 : rx_cnt + 1'b1;
            end
            if (push_req && fifo_full) rx_overflow <= 1'b1;
`ifdef SERIAL_LINK_PARITY_EN
            rx_spar_q <= rx_spar;
            if (rx_vld_q && ((^rx_sin_q) != rx_spar_q)) rx_perr <= 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_word;
    end

    // A push while full is dropped even if a pop happens in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rx_credit <= 1'b0;
        end else begin
            rx_credit <= pop;
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_link.sv
// Randomized and directed bench for serial_link: a queue-based word/beat scoreboard checks
// a 32-bit loopback/direct-RX instance, and a 10-bit instance covers padding.
module tb_serial_link;
    localparam int SW    = 4;
    localparam int PW    = 32;
    localparam int DEPTH = 2;
    localparam int BEATS = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, tx_svalid, tx_credit, rx_svalid, rx_credit;
    logic          out_valid, out_ready, rx_overflow;
    logic [PW-1:0] in_data, out_data;
    logic [SW-1:0] tx_sout, rx_sin;
    logic          lb, drv_svalid, drv_credit;
    logic [SW-1:0] drv_sin;

    assign rx_svalid = lb ? tx_svalid : drv_svalid;
    assign rx_sin    = lb ? tx_sout   : drv_sin;
    assign tx_credit = lb ? rx_credit : drv_credit;

    logic       in_valid10, in_ready10, tx_svalid10, rx_credit10, out_valid10, rx_overflow10;
    logic [9:0] in_data10, out_data10;
    logic [3:0] tx_sout10;

`ifdef SERIAL_LINK_PARITY_EN
    logic tx_spar, rx_spar, rx_perr, drv_spar, tx_spar10, rx_perr10;
    assign rx_spar = lb ? tx_spar : drv_spar;
`endif

    serial_link #(.SERIAL_WIDTH(SW), .PARALLEL_WIDTH(PW), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tx_svalid(tx_svalid), .tx_sout(tx_sout), .tx_credit(tx_credit),
        .rx_svalid(rx_svalid), .rx_sin(rx_sin), .rx_credit(rx_credit),
`ifdef SERIAL_LINK_PARITY_EN
        .tx_spar(tx_spar), .rx_spar(rx_spar), .rx_perr(rx_perr),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rx_overflow(rx_overflow)
    );

    serial_link #(.SERIAL_WIDTH(4), .PARALLEL_WIDTH(10), .FIFO_DEPTH(DEPTH)) u_dut10 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid10), .in_ready(in_ready10), .in_data(in_data10),
        .tx_svalid(tx_svalid10), .tx_sout(tx_sout10), .tx_credit(rx_credit10),
        .rx_svalid(tx_svalid10), .rx_sin(tx_sout10), .rx_credit(rx_credit10),
`ifdef SERIAL_LINK_PARITY_EN
        .tx_spar(tx_spar10), .rx_spar(tx_spar10), .rx_perr(rx_perr10),
`endif
        .out_valid(out_valid10), .out_ready(1'b1), .out_data(out_data10),
        .rx_overflow(rx_overflow10)
    );

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] word_q[$];
    logic [SW-1:0] beat_q[$];
    int   accepts;
    logic exp_ovf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Beat i of a pw-bit word: left-justify into BEATS*SW bits, take nibble i from the top.
    function automatic logic [SW-1:0] beat_of(input logic [63:0] w, input int pw, input int i);
        int nb;
        logic [63:0] p;
        nb = (pw + SW - 1) / SW;
        p  = w << (nb * SW - pw);
        return SW'((p >> ((nb - 1 - i) * SW)) & 64'hF);
    endfunction

    // Inputs are already set; record what the next edge does, then move to the next negedge.
    task automatic cycle();
        logic popped;
        if (in_valid && in_ready) begin
            accepts++;
            word_q.push_back(in_data);
            for (int i = 0; i < BEATS; i++) beat_q.push_back(beat_of(64'(in_data), PW, i));
        end
        popped = out_valid && out_ready;
        if (popped) begin
            if (word_q.size() == 0) chk("pop_unexpected", 64'(out_valid), 64'd0);
            else chk("out_data", 64'(out_data), 64'(word_q.pop_front()));
        end
        @(negedge clk);
        chk("rx_credit", 64'(rx_credit), 64'(popped));
        if (tx_svalid) begin
            if (beat_q.size() == 0) chk("beat_unexpected", 64'(tx_svalid), 64'd0);
            else chk("tx_sout", 64'(tx_sout), 64'(beat_q.pop_front()));
`ifdef SERIAL_LINK_PARITY_EN
            chk("tx_spar", 64'(tx_spar), 64'(^tx_sout));
`endif
        end
    endtask

    task automatic send_rx(input logic [PW-1:0] w, input int gap_at, input int gap_len,
                           input int bad_beat);
        for (int i = 0; i < BEATS; i++) begin
            drv_svalid = 1'b1;
            drv_sin    = beat_of(64'(w), PW, i);
`ifdef SERIAL_LINK_PARITY_EN
            drv_spar   = (^drv_sin) ^ (i == bad_beat);
`endif
            cycle();
            if (i == gap_at - 1) begin
                drv_svalid = 1'b0;
                drv_sin    = SW'($urandom);
                repeat (gap_len) cycle();
            end
        end
        drv_svalid = 1'b0;
        if (word_q.size() >= DEPTH) exp_ovf = 1'b1;
        else word_q.push_back(w);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        drv_svalid = 1'b0;
        drv_credit = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        word_q.delete();
        beat_q.delete();
        accepts = 0;
        exp_ovf = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        lb = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        drv_svalid = 1'b0; drv_sin = '0; drv_credit = 1'b0;
        in_valid10 = 1'b0; in_data10 = '0;
        accepts = 0; exp_ovf = 1'b0;
`ifdef SERIAL_LINK_PARITY_EN
        drv_spar = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_tx_svalid", 64'(tx_svalid), 64'd0);
        chk("rst_tx_sout", 64'(tx_sout), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_rx_credit", 64'(rx_credit), 64'd0);
        chk("rst_rx_overflow", 64'(rx_overflow), 64'd0);
        chk("rst_in_ready10", 64'(in_ready10), 64'd1);
`ifdef SERIAL_LINK_PARITY_EN
        chk("rst_rx_perr", 64'(rx_perr), 64'd0);
`endif

        // Loopback latency: beats on A+1..A+8, word visible at A+10.
        in_data  = 32'hDEADBEEF;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk("lat_tx_svalid", 64'(tx_svalid), 64'(k <= 8));
            chk("lat_out_valid", 64'(out_valid), 64'(k == 10));
            if (k == 10) chk("lat_out_data", 64'(out_data), 64'hDEADBEEF);
            if (k < 10) cycle();
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        repeat (2) cycle();

        // 10-bit word: three beats with the last one padded.
        in_data10  = 10'h3FF;
        in_valid10 = 1'b1;
        chk("w10_in_ready", 64'(in_ready10), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            in_valid10 = 1'b0;
            chk("w10_svalid", 64'(tx_svalid10), 64'(k <= 3));
            if (k <= 3) chk("w10_beat", 64'(tx_sout10), 64'(beat_of(64'h3FF, 10, k - 1)));
            chk("w10_out_valid", 64'(out_valid10), 64'(k == 5));
            if (k == 5) chk("w10_out_data", 64'(out_data10), 64'h3FF);
        end

        // Credit saturation and back-pressure through the credit loop.
        do_reset();
        lb = 1'b0;
        drv_credit = 1'b1;
        repeat (3) cycle();
        drv_credit = 1'b0;
        lb = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = $urandom;
            cycle();
        end
        chk("flow_accepts", 64'(accepts), 64'(DEPTH));
        chk("flow_in_ready_blocked", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 20 && accepts < 3; i++) begin
            in_data = $urandom;
            cycle();
        end
        in_valid = 1'b0;
        chk("flow_third_accept", 64'(accepts), 64'd3);
        out_ready = 1'b1;
        repeat (30) cycle();
        chk("flow_drained", 64'(word_q.size()), 64'd0);

        // Randomized loopback traffic.
        do_reset();
        lb = 1'b1;
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) cycle();
        chk("rand_words_left", 64'(word_q.size()), 64'd0);
        chk("rand_beats_left", 64'(beat_q.size()), 64'd0);
        chk("rand_no_overflow", 64'(rx_overflow), 64'd0);
`ifdef SERIAL_LINK_PARITY_EN
        chk("rand_no_perr", 64'(rx_perr), 64'd0);
`endif

        // Direct RX with a 3-cycle gap after beat 4.
        do_reset();
        lb = 1'b0;
        send_rx($urandom, 4, 3, -1);
        repeat (2) cycle();
        chk("gap_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        repeat (4) cycle();
        chk("gap_single_word", 64'(out_valid), 64'd0);
        chk("gap_model_empty", 64'(word_q.size()), 64'd0);

        // Overflow: third word dropped, first two intact.
        do_reset();
        lb = 1'b0;
        for (int i = 0; i < 3; i++) send_rx($urandom, 0, 0, -1);
        repeat (3) cycle();
        chk("ovf_flag", 64'(rx_overflow), 64'(exp_ovf));
        chk("ovf_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        repeat (4) cycle();
        chk("ovf_sticky", 64'(rx_overflow), 64'(exp_ovf));
        chk("ovf_drained", 64'(out_valid), 64'd0);
        chk("ovf_model_empty", 64'(word_q.size()), 64'd0);

`ifdef SERIAL_LINK_PARITY_EN
        // One flipped parity bit still delivers the word.
        do_reset();
        lb = 1'b0;
        send_rx($urandom, 0, 0, 5);
        repeat (3) cycle();
        chk("perr_flag", 64'(rx_perr), 64'd1);
        chk("perr_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("perr_model_empty", 64'(word_q.size()), 64'd0);
`endif

        // Reset in the middle of a transmitted word.
        do_reset();
        lb = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = $urandom;
        cycle();
        in_valid = 1'b0;
        repeat (2) cycle();
        chk("midrst_beat3_valid", 64'(tx_svalid), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_svalid_async", 64'(tx_svalid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        word_q.delete();
        beat_q.delete();
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        repeat (15) cycle();
        chk("midrst_no_write", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
